uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Byte-stream front end for `async_transmitter`. It buffers bytes written by the processor or host logic in a small synchronous FIFO and drains them one at a time through the transmitter's `TxD_start`/`TxD_data`/`TxD_busy` handshake. Producers can burst up to `Depth` bytes without tracking per-byte serial timing. Sits between the core's output port and the transmitter instance.

## Interface
Parameters:
- `Depth`, 16: FIFO entries; power of 2, range 2..256.
- `AddrWidth`, log2(`Depth`): pointer width, derived; do not override.

Ports:
- `clk`  in  1  system clock, the same clock as `async_transmitter`.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wr_en`  in  1  write strobe; one byte per cycle.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds `Depth` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  AddrWidth+1  current occupancy, 0..`Depth`.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `TxD_start`  out  1  one-cycle launch strobe to the transmitter.
- `TxD_data`  out  8  byte presented with `TxD_start`.
- `TxD_busy`  in  1  transmitter busy; goes high the cycle after an accepted start.

## Operation
- FIFO: circular buffer with read and write pointers of AddrWidth bits. Pointers wrap modulo `Depth`. `count` is tracked separately with AddrWidth+1 bits.
- Write acceptance: a write is accepted when `wr_en` is high and either `full` is low or a pop occurs in the same cycle.
  - Write while full with no pop: the data is dropped, `overflow` pulses for that cycle, and the FIFO is unchanged.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- FSM, three states:
  - IDLE: if `count`>0 and `TxD_busy`=0, then on the next edge register `TxD_start`=1 and `TxD_data`=head entry, pop the head, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `TxD_start` returns to 0 and `TxD_data` is held. If `TxD_busy`=1, go to WAIT; otherwise stay in LAUNCH.
  - WAIT: if `TxD_busy`=0, go to IDLE.
- `TxD_start` is high only on the single cycle after entering LAUNCH and never in consecutive cycles.
- `TxD_data` changes only on a pop edge and stays stable until the next pop.
- Reset (`rst_n`=0 at an edge): pointers and `count` go to 0 and the FSM goes to IDLE.
  - Outputs take their reset values: `TxD_start`=0, `TxD_data`=8'h00, `overflow`=0, `empty`=1, `full`=0, `count`=0.
  - Buffered bytes are discarded.
  - A transmitter byte already in flight completes because the transmitter has no reset. IDLE's `TxD_busy`=0 check prevents a new launch until it finishes.
- `wr_en` during reset is ignored.

## Timing
- Latency: a write accepted at edge N into an empty FIFO, with the FSM in IDLE and `TxD_busy`=0, gives `TxD_start`=1 during cycle N+1 (registered at edge N+1).
- Back-to-back bytes: each byte after the first launches on the edge after the first cycle in which `TxD_busy` is seen low in WAIT→IDLE. That is 2 cycles of gap after `TxD_busy` falls.
- Flags: `full`, `empty` and `count` reflect state after the last edge, all registered. `overflow` is registered and is high during the cycle after the dropped write.
- `TxD_busy` stuck low after a start: the FSM stays in LAUNCH indefinitely (no timeout). The FIFO still accepts writes.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2) and the default depth constant 16. The transmitter's baud constants also belong there.
- Sub-module `uart_sync_fifo`: depth-parameterised FIFO with write/pop/full/empty/count.
- Top module `uart_tx_feeder` contains the FSM and the output registers only.

## Test plan
- Single byte: write 8'hA5 into an idle block with a transmitter model (busy 1 cycle after start, then busy for 20 cycles). `TxD_start` pulses once, one cycle after the write, with `TxD_data`=8'hA5. `count` returns to 0.
- Burst: write 8'h01, 8'h02, 8'h03 on consecutive cycles. Three `TxD_start` pulses in order 01, 02, 03, each 2 cycles after the busy falling edge. Maximum `count` is 2.
- Overflow: hold the transmitter model busy and write 17 bytes. `full`=1 after 16 writes, the 17th write raises `overflow` for one cycle, and `count` stays 16. Releasing busy then drains exactly the first 16 bytes in order.
- Full plus pop: with the FIFO full, write during the pop cycle. The write is accepted, there is no overflow, `count` stays 16, and the byte appears after the older 15.
- Reset mid-transfer: with 4 bytes queued and busy high, pulse `rst_n`=0 for one cycle. The block returns to reset values. A write after reset does not launch until busy falls.
- Busy at reset release: hold `TxD_busy`=1 through reset and write one byte. No `TxD_start` until busy drops; `TxD_start` then comes 1 cycle after the drop.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: feeder FSM encoding, default FIFO depth,
// and the transmitter's baud settings.
package uart_pkg;

  localparam int DefaultDepth = 16;

  localparam int ClkFreq = 50_000_000;
  localparam int Baud    = 115_200;
  localparam int BaudDiv = ClkFreq / Baud;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side byte port plus the async_transmitter handshake
// of the UART transmit feeder.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int Depth = DefaultDepth
) ();

  localparam int AddrWidth = $clog2(Depth);

  logic                 wr_en;
  logic [7:0]           wr_data;
  logic                 full;
  logic                 empty;
  logic [AddrWidth:0]   count;
  logic                 overflow;
  logic                 TxD_start;
  logic [7:0]           TxD_data;
  logic                 TxD_busy;

  modport master (
    output wr_en,
    output wr_data,
    output TxD_busy,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  TxD_start,
    input  TxD_data
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  TxD_busy,
    output full,
    output empty,
    output count,
    output overflow,
    output TxD_start,
    output TxD_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with separate occupancy counter; a write is accepted
// when full only if a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int Depth     = DefaultDepth,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 pop_i,
  output logic [7:0]           head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [AddrWidth:0]   count_o,
  output logic                 overflow_o
);

  localparam logic [AddrWidth-1:0] PtrOne = 1;
  localparam logic [AddrWidth:0]   CntOne = 1;
  localparam logic [AddrWidth:0]   CntMax = (AddrWidth+1)'(Depth);

  logic [7:0]           mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 pop;
  logic                 push;

  assign full_o     = (count_q == CntMax);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign head_o     = mem_q[rd_ptr_q];

  assign pop  = pop_i && !empty_o;
  assign push = wr_en_i && (!full_o || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en_i && !push;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; stale entries sit behind rd_ptr.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains the byte FIFO into async_transmitter one byte at a time
// using the TxD_start / TxD_busy handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int Depth     = DefaultDepth,
  parameter int AddrWidth = $clog2(Depth)
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_feeder_if.slave  bus
);

  tx_state_e  state_q, state_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       pop;
  logic [7:0] head;
  logic       fifo_empty;

  uart_sync_fifo #(
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (bus.full),
    .empty_o    (fifo_empty),
    .count_o    (bus.count),
    .overflow_o (bus.overflow)
  );

  assign bus.empty     = fifo_empty;
  assign bus.TxD_start = start_q;
  assign bus.TxD_data  = data_q;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.TxD_busy) begin
          pop     = 1'b1;
          start_d = 1'b1;
          data_d  = head;
          state_d = LAUNCH;
        end
      end
      // Stays here forever if busy never rises.
      LAUNCH: if (bus.TxD_busy) state_d = WAIT;
      WAIT:   if (!bus.TxD_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: per-cycle vector table plus
// multi-cycle sequences against a simple transmitter busy model.
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_busy = 1'b0;
  logic model_en = 1'b0;
  int   bcnt = 0;
  int   cyc = 0;

  int checks = 0;
  int failures = 0;

  uart_tx_feeder_if #(.Depth(16)) bus ();

  uart_tx_feeder #(.Depth(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Transmitter: busy the cycle after a start, for 20 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!model_en) bcnt <= 0;
    else if (bus.TxD_start) bcnt <= 20;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  assign bus.TxD_busy = tb_busy | (bcnt != 0);

  logic [7:0] st_data[$];
  int         st_cyc[$];
  int         fall_cyc[$];
  int         maxcnt = 0;
  int         consec = 0;
  logic       prev_start = 1'b0;
  logic       prev_busy = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (bus.TxD_start === 1'b1) begin
      st_data.push_back(bus.TxD_data);
      st_cyc.push_back(cyc);
      if (prev_start) consec++;
    end
    prev_start = (bus.TxD_start === 1'b1);
    if (prev_busy && !bus.TxD_busy) fall_cyc.push_back(cyc);
    prev_busy = bus.TxD_busy;
    if (int'(bus.count) > maxcnt) maxcnt = int'(bus.count);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_logs();
    st_data.delete();
    st_cyc.delete();
    fall_cyc.delete();
    maxcnt = 0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    cyc1();
    bus.wr_en = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       st;
    logic [7:0] td;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vt[14];

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;

    vt[0]  = '{0,1,8'hFF,0, 0,8'h00,5'd0,0,1,0};
    vt[1]  = '{1,1,8'hA5,1, 0,8'h00,5'd1,0,0,0};
    vt[2]  = '{1,0,8'h00,1, 0,8'h00,5'd1,0,0,0};
    vt[3]  = '{1,0,8'h00,0, 1,8'hA5,5'd0,0,1,0};
    vt[4]  = '{1,1,8'h3C,0, 0,8'hA5,5'd1,0,0,0};
    vt[5]  = '{1,0,8'h00,0, 0,8'hA5,5'd1,0,0,0};
    vt[6]  = '{1,0,8'h00,1, 0,8'hA5,5'd1,0,0,0};
    vt[7]  = '{1,0,8'h00,1, 0,8'hA5,5'd1,0,0,0};
    vt[8]  = '{1,0,8'h00,0, 0,8'hA5,5'd1,0,0,0};
    vt[9]  = '{1,0,8'h00,0, 1,8'h3C,5'd0,0,1,0};
    vt[10] = '{1,1,8'h77,1, 0,8'h3C,5'd1,0,0,0};
    vt[11] = '{0,1,8'h11,1, 0,8'h00,5'd0,0,1,0};
    vt[12] = '{1,1,8'h22,1, 0,8'h00,5'd1,0,0,0};
    vt[13] = '{1,0,8'h00,0, 1,8'h22,5'd0,0,1,0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst_n = vt[i].rst;
      bus.wr_en = vt[i].wr;
      bus.wr_data = vt[i].d;
      tb_busy = vt[i].busy;
      cyc1();
      chk($sformatf("v%0d_start", i), 32'(bus.TxD_start), 32'(vt[i].st));
      chk($sformatf("v%0d_data", i), 32'(bus.TxD_data), 32'(vt[i].td));
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vt[i].full));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vt[i].empty));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vt[i].ovf));
    end
    bus.wr_en = 1'b0;
    tb_busy = 1'b0;
    rst_n = 1'b0;
    cyc1();
    rst_n = 1'b1;
    model_en = 1'b1;
    cyc1();

    // Single byte
    clr_logs();
    wr(8'hA5);
    chk("A_cnt1", 32'(bus.count), 32'd1);
    chk("A_nostart", 32'(bus.TxD_start), 32'd0);
    cyc1();
    chk("A_start", 32'(bus.TxD_start), 32'd1);
    chk("A_data", 32'(bus.TxD_data), 32'hA5);
    chk("A_cnt0", 32'(bus.count), 32'd0);
    repeat (40) cyc1();
    chk("A_npulse", 32'(st_data.size()), 32'd1);
    chk("A_empty", 32'(bus.empty), 32'd1);

    // Burst of three
    clr_logs();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    repeat (100) cyc1();
    chk("B_npulse", 32'(st_data.size()), 32'd3);
    if (st_data.size() == 3) begin
      chk("B_d0", 32'(st_data[0]), 32'h01);
      chk("B_d1", 32'(st_data[1]), 32'h02);
      chk("B_d2", 32'(st_data[2]), 32'h03);
    end
    chk("B_maxcnt", 32'(maxcnt), 32'd2);
    if (st_cyc.size() == 3 && fall_cyc.size() >= 2) begin
      chk("B_gap1", 32'(st_cyc[1] - fall_cyc[0]), 32'd2);
      chk("B_gap2", 32'(st_cyc[2] - fall_cyc[1]), 32'd2);
    end else begin
      chk("B_falls", 32'(fall_cyc.size()), 32'd3);
    end

    // Overflow while busy held
    clr_logs();
    tb_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    chk("C_full", 32'(bus.full), 32'd1);
    chk("C_cnt16", 32'(bus.count), 32'd16);
    chk("C_noovf", 32'(bus.overflow), 32'd0);
    wr(8'hEE);
    chk("C_ovf", 32'(bus.overflow), 32'd1);
    chk("C_cnt16b", 32'(bus.count), 32'd16);
    chk("C_fullb", 32'(bus.full), 32'd1);
    cyc1();
    chk("C_ovf_pulse", 32'(bus.overflow), 32'd0);
    clr_logs();
    tb_busy = 1'b0;
    repeat (450) cyc1();
    chk("C_npulse", 32'(st_data.size()), 32'd16);
    if (st_data.size() == 16)
      for (int i = 0; i < 16; i++)
        chk($sformatf("C_d%0d", i), 32'(st_data[i]), 32'(8'h10 + i));

    // Full plus pop in the same cycle
    clr_logs();
    tb_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    chk("D_full", 32'(bus.full), 32'd1);
    clr_logs();
    tb_busy = 1'b0;
    wr(8'hAB);
    chk("D_cnt16", 32'(bus.count), 32'd16);
    chk("D_noovf", 32'(bus.overflow), 32'd0);
    chk("D_full2", 32'(bus.full), 32'd1);
    chk("D_start", 32'(bus.TxD_start), 32'd1);
    chk("D_data", 32'(bus.TxD_data), 32'h40);
    repeat (500) cyc1();
    chk("D_npulse", 32'(st_data.size()), 32'd17);
    if (st_data.size() == 17) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("D_d%0d", i), 32'(st_data[i]), 32'(8'h40 + i));
      chk("D_last", 32'(st_data[16]), 32'hAB);
    end

    // Reset mid-transfer
    clr_logs();
    tb_busy = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(8'h61 + i));
    chk("E_cnt4", 32'(bus.count), 32'd4);
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h99;
    cyc1();
    bus.wr_en = 1'b0;
    chk("E_rcnt", 32'(bus.count), 32'd0);
    chk("E_rempty", 32'(bus.empty), 32'd1);
    chk("E_rfull", 32'(bus.full), 32'd0);
    chk("E_rstart", 32'(bus.TxD_start), 32'd0);
    chk("E_rdata", 32'(bus.TxD_data), 32'h00);
    chk("E_rovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    wr(8'h5A);
    repeat (5) cyc1();
    chk("E_nolaunch", 32'(st_data.size()), 32'd0);
    chk("E_cnt1", 32'(bus.count), 32'd1);
    tb_busy = 1'b0;
    repeat (5) cyc1();
    chk("E_npulse", 32'(st_data.size()), 32'd1);
    if (st_data.size() == 1)
      chk("E_data", 32'(st_data[0]), 32'h5A);
    repeat (30) cyc1();

    // Busy held through reset release
    clr_logs();
    tb_busy = 1'b1;
    rst_n = 1'b0;
    cyc1();
    rst_n = 1'b1;
    wr(8'hC3);
    repeat (6) cyc1();
    chk("F_nolaunch", 32'(st_data.size()), 32'd0);
    tb_busy = 1'b0;
    repeat (3) cyc1();
    chk("F_npulse", 32'(st_data.size()), 32'd1);
    if (st_data.size() == 1 && fall_cyc.size() == 1) begin
      chk("F_data", 32'(st_data[0]), 32'hC3);
      chk("F_lat", 32'(st_cyc[0] - fall_cyc[0]), 32'd1);
    end else begin
      chk("F_falls", 32'(fall_cyc.size()), 32'd1);
    end
    repeat (30) cyc1();

    chk("no_consec_start", 32'(consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
